// File: rtl/frog_life_controller.sv
// ---------------------------------------------------------------------------
// frog_life_controller
//
// Game-state keeper for the frog game. Sits right after the collision
// checker and tracks lives, level and game-over. It also tells the frog and
// car movement blocks when to freeze and when the frog must respawn. Timing
// of the post-hit freeze is paced by the per-frame tick from the VGA timing
// block.
//
// Optional feature macro: FROG_LIFE_GRACE_EN
//   When defined, every respawn opens a window of GRACE_TICKS frames.
//   Collisions are ignored during that window. When undefined, a collision
//   edge counts on the very next cycle after a respawn.
//
// Ports:
//   i_Clk          system clock
//   i_Rst_N        asynchronous active-low reset
//   i_Frame_Tick   one-cycle pulse per video frame
//   i_Start        start/restart request (level sampled)
//   i_Has_Collided registered collision flag, high while frog overlaps a car
//   i_Frog_Y       frog top-left Y position
//   o_Lives        remaining lives
//   o_Level        current level (saturates at MAX_LEVEL)
//   o_Freeze       1 = movement blocks hold their positions
//   o_Respawn      one-cycle pulse, frog returns to its start tile
//   o_Level_Up     one-cycle pulse when the goal row is reached
//   o_Game_Over    high while in GAME_OVER
// ---------------------------------------------------------------------------
module frog_life_controller #(
  parameter int INIT_LIVES       = 3,
  parameter int HIT_FREEZE_TICKS = 60,
  parameter int GRACE_TICKS      = 30,
  parameter int GOAL_ROW_Y       = 0,
  parameter int MAX_LEVEL        = 15
) (
  input  logic       i_Clk,
  input  logic       i_Rst_N,
  input  logic       i_Frame_Tick,
  input  logic       i_Start,
  input  logic       i_Has_Collided,
  input  logic [9:0] i_Frog_Y,
  output logic [2:0] o_Lives,
  output logic [3:0] o_Level,
  output logic       o_Freeze,
  output logic       o_Respawn,
  output logic       o_Level_Up,
  output logic       o_Game_Over
);

  // One counter width serves both the freeze counter and the grace counter,
  // never narrower than 8 bits.
  localparam int FREEZE_W = $clog2(HIT_FREEZE_TICKS + 1);
  localparam int GRACE_W  = $clog2(GRACE_TICKS + 1);
  localparam int WIDE_W   = (FREEZE_W > GRACE_W) ? FREEZE_W : GRACE_W;
  localparam int CNT_W    = (WIDE_W > 8) ? WIDE_W : 8;

  localparam logic [2:0]       LIVES_INIT   = 3'(INIT_LIVES);
  localparam logic [3:0]       LEVEL_MAX    = 4'(MAX_LEVEL);
  localparam logic [9:0]       GOAL_Y       = 10'(GOAL_ROW_Y);
  localparam logic [CNT_W-1:0] FREEZE_COUNT = CNT_W'(HIT_FREEZE_TICKS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PLAY,
    ST_HIT,
    ST_GAME_OVER
  } state_e;

  state_e           state_q;
  logic [2:0]       lives_q;
  logic [3:0]       level_q;
  logic             freeze_q;
  logic             respawn_q;
  logic             levelUp_q;
  logic             gameOver_q;
  logic             collPrev_q;
  logic             goalArmed_q;
  logic [CNT_W-1:0] frameCnt_q;

`ifdef FROG_LIFE_GRACE_EN
  localparam logic [CNT_W-1:0] GRACE_LOAD = CNT_W'(GRACE_TICKS);
  logic [CNT_W-1:0] graceCnt_q;
`endif

  logic             collEdge;
  logic             atGoal;
  logic             graceActive;
  logic             hitTaken;
  logic             goalTaken;
  logic             startTaken;
  logic             freezeDone;
  logic             respawnNext;
  logic [CNT_W-1:0] frameCntInc;

  // Decision logic shared by the FSM and the grace counter. A hit is the
  // rising edge of the collision flag, so a flag that stays high across a
  // respawn cannot count twice. A hit always beats a goal in the same cycle,
  // and the goal only counts once per visit to the goal row (goalArmed_q).
  always_comb begin
    frameCntInc = frameCnt_q + CNT_W'(1);
    collEdge    = i_Has_Collided & ~collPrev_q;
    atGoal      = (i_Frog_Y == GOAL_Y);
`ifdef FROG_LIFE_GRACE_EN
    graceActive = (graceCnt_q != '0);
`else
    graceActive = 1'b0;
`endif
    hitTaken    = (state_q == ST_PLAY) && collEdge && !graceActive;
    goalTaken   = (state_q == ST_PLAY) && !hitTaken && atGoal && goalArmed_q;
    startTaken  = ((state_q == ST_IDLE) || (state_q == ST_GAME_OVER)) && i_Start;
    freezeDone  = (state_q == ST_HIT) && i_Frame_Tick && (frameCntInc == FREEZE_COUNT);
    respawnNext = startTaken || goalTaken || (freezeDone && (lives_q != 3'd0));
  end

  // Main game FSM with all outputs registered. Each decision lands on the
  // same edge that samples its condition. The collision history and the goal
  // re-arm flag update every cycle regardless of state.
  always_ff @(posedge i_Clk or negedge i_Rst_N) begin
    if (!i_Rst_N) begin
      state_q     <= ST_IDLE;
      lives_q     <= LIVES_INIT;
      level_q     <= 4'd0;
      freeze_q    <= 1'b1;
      respawn_q   <= 1'b0;
      levelUp_q   <= 1'b0;
      gameOver_q  <= 1'b0;
      collPrev_q  <= 1'b0;
      goalArmed_q <= 1'b1;
      frameCnt_q  <= '0;
    end else begin
      collPrev_q <= i_Has_Collided;
      respawn_q  <= respawnNext;
      levelUp_q  <= goalTaken;

      if (!atGoal) begin
        goalArmed_q <= 1'b1;
      end else if (goalTaken) begin
        goalArmed_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE, ST_GAME_OVER: begin
          freeze_q <= 1'b1;
          if (startTaken) begin
            state_q    <= ST_PLAY;
            lives_q    <= LIVES_INIT;
            level_q    <= 4'd0;
            freeze_q   <= 1'b0;
            gameOver_q <= 1'b0;
          end
        end

        ST_PLAY: begin
          freeze_q <= 1'b0;
          if (hitTaken) begin
            state_q    <= ST_HIT;
            freeze_q   <= 1'b1;
            frameCnt_q <= '0;
            if (lives_q != 3'd0) begin
              lives_q <= lives_q - 3'd1;
            end
          end else if (goalTaken && (level_q != LEVEL_MAX)) begin
            level_q <= level_q + 4'd1;
          end
        end

        ST_HIT: begin
          freeze_q <= 1'b1;
          if (i_Frame_Tick) begin
            frameCnt_q <= frameCntInc;
            if (freezeDone) begin
              if (lives_q == 3'd0) begin
                state_q    <= ST_GAME_OVER;
                gameOver_q <= 1'b1;
              end else begin
                state_q  <= ST_PLAY;
                freeze_q <= 1'b0;
              end
            end
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef FROG_LIFE_GRACE_EN
  // Grace window after every respawn. The load shares the respawn decision so
  // the window is already open on the first cycle the frog is back in play.
  // It only counts down on frame ticks while actually playing.
  always_ff @(posedge i_Clk or negedge i_Rst_N) begin
    if (!i_Rst_N) begin
      graceCnt_q <= '0;
    end else if (respawnNext) begin
      graceCnt_q <= GRACE_LOAD;
    end else if ((state_q == ST_PLAY) && i_Frame_Tick && (graceCnt_q != '0)) begin
      graceCnt_q <= graceCnt_q - CNT_W'(1);
    end
  end
`endif

  assign o_Lives     = lives_q;
  assign o_Level     = level_q;
  assign o_Freeze    = freeze_q;
  assign o_Respawn   = respawn_q;
  assign o_Level_Up  = levelUp_q;
  assign o_Game_Over = gameOver_q;

endmodule

// File: tb/tb_frog_life_controller.sv
// ---------------------------------------------------------------------------
// tb_frog_life_controller
//
// Directed bench for frog_life_controller with default parameters
// (3 lives, 60-frame freeze, 30-frame grace, goal row 0, max level 15).
// Inputs change 1 ns after a rising edge and outputs are sampled 1 ns after
// the next rising edge. Build with FROG_LIFE_GRACE_EN defined to exercise the
// grace window; otherwise the immediate-hit-after-respawn path is exercised.
// ---------------------------------------------------------------------------
module tb_frog_life_controller;

  logic       clk = 1'b0;
  logic       rstN;
  logic       frameTick;
  logic       start;
  logic       coll;
  logic [9:0] frogY;
  logic [2:0] lives;
  logic [3:0] level;
  logic       freeze;
  logic       respawn;
  logic       levelUp;
  logic       gameOver;

  int checkCount    = 0;
  int errorCount    = 0;
  int levelUpPulses = 0;
  int expLevel;

  frog_life_controller dut (
    .i_Clk          (clk),
    .i_Rst_N        (rstN),
    .i_Frame_Tick   (frameTick),
    .i_Start        (start),
    .i_Has_Collided (coll),
    .i_Frog_Y       (frogY),
    .o_Lives        (lives),
    .o_Level        (level),
    .o_Freeze       (freeze),
    .o_Respawn      (respawn),
    .o_Level_Up     (levelUp),
    .o_Game_Over    (gameOver)
  );

  // 100 MHz-style free-running clock.
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: still running at %0t, required finish before 200000", $time);
    $fatal(1, "[TB] timeout");
  end

  // Advance one clock and sample just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    levelUpPulses += int'(levelUp);
  endtask

  // Drive all functional inputs, then advance one clock.
  task automatic applyStimulus(input logic st, input logic cl, input logic tk,
                               input logic [9:0] y);
    start     = st;
    coll      = cl;
    frameTick = tk;
    frogY     = y;
    step();
  endtask

  // Pulse the frame tick n times, one idle cycle between pulses.
  task automatic tickFrames(input int n);
    for (int k = 0; k < n; k++) begin
      frameTick = 1'b1;
      step();
      frameTick = 1'b0;
      step();
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) else begin
      errorCount++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag, input int eLives, input int eLevel,
                          input int eFreeze, input int eRespawn, input int eLevelUp,
                          input int eGameOver);
    checkOutput($sformatf("%s.lives", tag),    32'(lives),    32'(eLives));
    checkOutput($sformatf("%s.level", tag),    32'(level),    32'(eLevel));
    checkOutput($sformatf("%s.freeze", tag),   32'(freeze),   32'(eFreeze));
    checkOutput($sformatf("%s.respawn", tag),  32'(respawn),  32'(eRespawn));
    checkOutput($sformatf("%s.levelUp", tag),  32'(levelUp),  32'(eLevelUp));
    checkOutput($sformatf("%s.gameOver", tag), 32'(gameOver), 32'(eGameOver));
  endtask

  initial begin
    rstN      = 1'b0;
    start     = 1'b0;
    coll      = 1'b0;
    frameTick = 1'b0;
    frogY     = 10'd100;

    // Reset values while reset is held.
    repeat (2) @(posedge clk);
    #1;
    checkAll("reset", 3, 0, 1, 0, 0, 0);
    rstN = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 10'd100);
    applyStimulus(1'b0, 1'b0, 1'b0, 10'd100);
    checkOutput("idle_freeze", 32'(freeze), 32'd1);

    // Start: lives/level loaded, one respawn pulse, movement released.
    applyStimulus(1'b1, 1'b0, 1'b0, 10'd100);
    checkAll("start", 3, 0, 0, 1, 0, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 10'd100);
    checkOutput("start_respawn_once", 32'(respawn), 32'd0);
    checkOutput("start_freeze", 32'(freeze), 32'd0);
    tickFrames(31);

    // First hit with the flag held 10 cycles: a single decrement.
    applyStimulus(1'b0, 1'b1, 1'b0, 10'd100);
    checkAll("hit1", 2, 0, 1, 0, 0, 0);
    repeat (9) step();
    checkOutput("hit1_held_lives", 32'(lives), 32'd2);
    tickFrames(59);
    checkOutput("hit1_still_frozen", 32'(freeze), 32'd1);
    checkOutput("hit1_no_early_respawn", 32'(respawn), 32'd0);
    frameTick = 1'b1;
    step();
    frameTick = 1'b0;
    checkAll("hit1_release", 2, 0, 0, 1, 0, 0);
    step();
    checkOutput("hit1_flag_held_lives", 32'(lives), 32'd2);
    checkOutput("hit1_respawn_done", 32'(respawn), 32'd0);
    checkOutput("hit1_play_freeze", 32'(freeze), 32'd0);
    coll = 1'b0;
    step();
    tickFrames(31);

    // Second and third hits lead to game over.
    applyStimulus(1'b0, 1'b1, 1'b0, 10'd100);
    checkAll("hit2", 1, 0, 1, 0, 0, 0);
    coll = 1'b0;
    step();
    tickFrames(60);
    checkAll("hit2_back", 1, 0, 0, 0, 0, 0);
    tickFrames(31);
    applyStimulus(1'b0, 1'b1, 1'b0, 10'd100);
    checkAll("hit3", 0, 0, 1, 0, 0, 0);
    coll = 1'b0;
    step();
    tickFrames(60);
    checkAll("game_over", 0, 0, 1, 0, 0, 1);
    step();
    checkOutput("game_over_hold", 32'(gameOver), 32'd1);

    // Restart from game over.
    applyStimulus(1'b1, 1'b0, 1'b0, 10'd100);
    checkAll("restart", 3, 0, 0, 1, 0, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 10'd100);
    tickFrames(31);

    // Goal held for 5 cycles: exactly one level-up.
    levelUpPulses = 0;
    frogY = 10'd0;
    repeat (5) step();
    checkOutput("goal_pulses", 32'(levelUpPulses), 32'd1);
    checkOutput("goal_level", 32'(level), 32'd1);
    frogY = 10'd100;
    step();
    for (int i = 2; i <= 16; i++) begin
      frogY = 10'd0;
      step();
      expLevel = (i > 15) ? 15 : i;
      checkOutput($sformatf("goal_level_%0d", i), 32'(level), 32'(expLevel));
      frogY = 10'd100;
      step();
    end
    checkOutput("goal_total_pulses", 32'(levelUpPulses), 32'd16);
    checkOutput("goal_saturated", 32'(level), 32'd15);
    tickFrames(31);

    // Hit and goal on the same cycle: the hit wins.
    applyStimulus(1'b0, 1'b1, 1'b0, 10'd0);
    checkAll("hit_vs_goal", 2, 15, 1, 0, 0, 0);
    step();
    checkOutput("hit_vs_goal_no_levelup", 32'(levelUp), 32'd0);
    checkOutput("hit_vs_goal_frozen", 32'(freeze), 32'd1);
    checkOutput("hit_vs_goal_pulses", 32'(levelUpPulses), 32'd16);

    // Reset asserted mid-HIT takes effect without a clock edge.
    rstN = 1'b0;
    #2;
    checkAll("async_reset", 3, 0, 1, 0, 0, 0);
    coll  = 1'b0;
    frogY = 10'd100;
    @(posedge clk);
    #1;
    rstN = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 10'd100);
    checkAll("start_after_reset", 3, 0, 0, 1, 0, 0);

`ifdef FROG_LIFE_GRACE_EN
    start = 1'b0;
    tickFrames(10);
    applyStimulus(1'b0, 1'b1, 1'b0, 10'd100);
    checkOutput("grace_ignored_hit", 32'(lives), 32'd3);
    coll = 1'b0;
    step();
    tickFrames(20);
    applyStimulus(1'b0, 1'b1, 1'b1, 10'd100);
    checkOutput("grace_expired_hit", 32'(lives), 32'd2);
    checkOutput("grace_expired_freeze", 32'(freeze), 32'd1);
`else
    applyStimulus(1'b0, 1'b1, 1'b0, 10'd100);
    checkOutput("hit_right_after_respawn", 32'(lives), 32'd2);
    checkOutput("hit_right_after_respawn_freeze", 32'(freeze), 32'd1);
`endif
    frameTick = 1'b0;
    coll      = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/frog_life_controller.md
Name: frog_life_controller

Overview:
Game-state stage directly downstream of the collision checker. It consumes the registered, level-type collision flag together with the frog position, and it tracks lives, level and game-over. It also issues freeze and respawn commands to the frog movement and car movement blocks. It is paced by the per-frame tick from the VGA timing block.

Parameters:
INIT_LIVES, 3, lives loaded on start; range 1..7
HIT_FREEZE_TICKS, 60, frames the game stays frozen after a hit
GRACE_TICKS, 30, frames of collision immunity after a respawn (only with the optional feature)
GOAL_ROW_Y, 0, frog Y value that counts as reaching the far side
MAX_LEVEL, 15, level saturation value

Ports:
i_Clk  in  1  system clock
i_Rst_N  in  1  asynchronous active-low reset
i_Frame_Tick  in  1  one-cycle pulse per video frame
i_Start  in  1  start/restart request, sampled as a level
i_Has_Collided  in  1  registered collision flag; stays high while the frog overlaps a car
i_Frog_Y  in  10  frog top-left Y position
o_Lives  out  3  remaining lives
o_Level  out  4  current level
o_Freeze  out  1  1 = movement blocks must hold their positions
o_Respawn  out  1  one-cycle pulse: frog returns to its start tile
o_Level_Up  out  1  one-cycle pulse on goal reached
o_Game_Over  out  1  high while in GAME_OVER

Behaviour:
- Reset is asynchronous and active-low; one clock, i_Clk. A reset at any time forces the IDLE state and aborts any freeze or grace count.
- Reset values: o_Lives=INIT_LIVES, o_Level=0, o_Freeze=1, o_Respawn=0, o_Level_Up=0, o_Game_Over=0. Collision history register=0, frame counter=0.
- Collision edge: hit = i_Has_Collided & ~prev, where prev is the value registered one cycle earlier. prev updates every cycle in every state. A flag held high across a respawn never counts twice; it must drop before it can count again.
- All outputs are registered. Each decision takes effect on the clock edge where its condition is sampled, so outputs change 1 cycle after the input.
- States:
  - IDLE: o_Freeze=1. When i_Start=1, go to PLAY; load o_Lives=INIT_LIVES and o_Level=0; pulse o_Respawn.
  - PLAY: o_Freeze=0. i_Start is ignored.
    - On hit: go to HIT; o_Lives decrements by 1; o_Freeze=1; frame counter clears.
    - Otherwise, when i_Frog_Y == GOAL_ROW_Y: pulse o_Level_Up and o_Respawn; o_Level increments, saturating at MAX_LEVEL; stay in PLAY.
    - A hit and a goal in the same cycle: the hit wins and no level-up occurs.
    - The goal condition must be re-armed: after a level-up it is ignored until i_Frog_Y != GOAL_ROW_Y has been sampled. This prevents repeats before the respawn lands.
  - HIT: o_Freeze=1. The frame counter increments on each i_Frame_Tick. On the tick that brings the count to HIT_FREEZE_TICKS:
    - if o_Lives==0, go to GAME_OVER with o_Game_Over=1;
    - otherwise go to PLAY, pulse o_Respawn, and set o_Freeze=0.
    - Collisions are ignored while in HIT.
  - GAME_OVER: o_Freeze=1, o_Game_Over=1. When i_Start=1, act as the IDLE start path and clear o_Game_Over.
- o_Lives never wraps below 0; the decrement happens only in PLAY, where o_Lives is at least 1. o_Level never exceeds MAX_LEVEL.
- Frame counter width is at least 8 bits; the comparison is equality against the parameter.

Optional Feature:
FROG_LIFE_GRACE_EN
- Defined: every o_Respawn pulse loads a grace counter with GRACE_TICKS. The counter decrements on i_Frame_Tick while in PLAY. Hits are ignored while it is nonzero, but the edge history still updates.
- Undefined: there is no grace counter, and hits count immediately on the cycle after a respawn.

Test Plan:
1. Reset, then i_Start=1 for 1 cycle -> o_Lives=3, o_Level=0, o_Respawn high for exactly 1 cycle, o_Freeze=0 on the next cycle.
2. In PLAY, raise i_Has_Collided and hold it for 10 cycles -> o_Lives=2 one cycle after the rise, single decrement, o_Freeze=1. After 60 frame ticks -> o_Respawn pulse, o_Freeze=0. With the flag still high, o_Lives remains 2.
3. Three separate collision edges, each followed by its 60-tick freeze -> after the third freeze o_Game_Over=1, o_Lives=0, o_Freeze=1. Then i_Start -> o_Lives=3, o_Game_Over=0.
4. Set i_Frog_Y=0 for 5 cycles -> exactly one o_Level_Up pulse and o_Level=1. Repeat 16 times -> o_Level stays at 15.
5. Assert a collision edge and i_Frog_Y=0 on the same cycle -> o_Lives decrements, no o_Level_Up, state HIT.
6. With FROG_LIFE_GRACE_EN defined, raise a collision edge 10 ticks after a respawn -> no decrement. An edge at tick 31 -> decrement. Pull i_Rst_N low mid-HIT -> outputs return to their reset values immediately, without waiting for a clock edge.
